// File: rtl/decode_stage.sv
// decode_stage -- MIPS32 integer-subset instruction decode with an integrated
// ID/EX pipeline register.
//
// Purpose:
//   Decodes the instruction presented by IF/ID and reads the register file
//   through combinational read ports. Operands are resolved by EX/MEM
//   forwarding or by a hazard stall. The decoded bundle is then registered
//   toward execute behind a valid/ready handshake. The block also supports
//   flush and counts hazard-stall cycles in a saturating counter.
//
// Configuration macro:
//   DECODE_FORWARD_EN  defined   : EX/MEM forwarding; only load-use stalls.
//                      undefined : no forwarding; stall on any pending
//                                  EX or MEM write to a used source register.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       handshake from IF/ID
//   pc_i, inst_i              instruction address and word
//   reg{1,2}_read_o/_addr_o   combinational regfile read enable/address
//   reg{1,2}_data_i           regfile read data (same cycle)
//   ex_*_i, mem_*_i           EX / MEM writeback info for forwarding/hazards
//   flush_i                   kill in-flight and incoming instruction
//   out_valid / out_ready     handshake to EX
//   pc_o .. invalid_o         registered decoded bundle
//   stall_cnt_o               saturating count of hazard-stall cycles
module decode_stage #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int RADDR_W     = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [31:0]            inst_i,
    output logic                   reg1_read_o,
    output logic                   reg2_read_o,
    output logic [RADDR_W-1:0]     reg1_addr_o,
    output logic [RADDR_W-1:0]     reg2_addr_o,
    input  logic [DATA_W-1:0]      reg1_data_i,
    input  logic [DATA_W-1:0]      reg2_data_i,
    input  logic                   ex_wreg_i,
    input  logic [RADDR_W-1:0]     ex_wd_i,
    input  logic [DATA_W-1:0]      ex_wdata_i,
    input  logic                   ex_is_load_i,
    input  logic                   mem_wreg_i,
    input  logic [RADDR_W-1:0]     mem_wd_i,
    input  logic [DATA_W-1:0]      mem_wdata_i,
    input  logic                   flush_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc_o,
    output logic [7:0]             aluop_o,
    output logic [2:0]             alusel_o,
    output logic [DATA_W-1:0]      reg1_o,
    output logic [DATA_W-1:0]      reg2_o,
    output logic [DATA_W-1:0]      imm_o,
    output logic [RADDR_W-1:0]     wd_o,
    output logic                   wreg_o,
    output logic                   mem_re_o,
    output logic                   mem_we_o,
    output logic                   invalid_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MEM   = 3'b111;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [5:0]         op, funct;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]  imm_zext, imm_lui;
    logic signed [DATA_W-1:0] imm_sext;

    assign op       = inst_i[31:26];
    assign funct    = inst_i[5:0];
    assign rs       = RADDR_W'(inst_i[25:21]);
    assign rt       = RADDR_W'(inst_i[20:16]);
    assign rd       = RADDR_W'(inst_i[15:11]);
    assign imm_zext = DATA_W'(inst_i[15:0]);
    assign imm_sext = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
    assign imm_lui  = DATA_W'({inst_i[15:0], 16'h0000});

    logic [7:0]         dec_aluop;
    logic [2:0]         dec_alusel;
    logic               dec_wreg, dec_re1, dec_re2, dec_mre, dec_mwe, dec_inv;
    logic [RADDR_W-1:0] dec_wd;
    logic [DATA_W-1:0]  dec_imm;

    always_comb begin
        dec_aluop  = 8'h00;
        dec_alusel = 3'b000;
        dec_wreg   = 1'b0;
        dec_wd     = rt;
        dec_re1    = 1'b0;
        dec_re2    = 1'b0;
        dec_mre    = 1'b0;
        dec_mwe    = 1'b0;
        dec_inv    = 1'b0;
        dec_imm    = '0;
        case (op)
            6'h00: begin
                // An all-zero word is NOP; any other unknown funct is invalid.
                if (inst_i != 32'h0) begin
                    dec_re1  = 1'b1;
                    dec_re2  = 1'b1;
                    dec_wreg = 1'b1;
                    dec_wd   = rd;
                    case (funct)
                        6'h24, 6'h25, 6'h26, 6'h27: begin
                            dec_aluop  = {2'b00, funct};
                            dec_alusel = SEL_LOGIC;
                        end
                        6'h20, 6'h21, 6'h22, 6'h2A: begin
                            dec_aluop  = {2'b00, funct};
                            dec_alusel = SEL_ARITH;
                        end
                        default: begin
                            dec_inv  = 1'b1;
                            dec_re1  = 1'b0;
                            dec_re2  = 1'b0;
                            dec_wreg = 1'b0;
                        end
                    endcase
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_aluop  = (op == 6'h0C) ? 8'h24 : (op == 6'h0D) ? 8'h25 : 8'h26;
                dec_alusel = SEL_LOGIC;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_imm    = imm_zext;
            end
            6'h0F: begin
                dec_aluop  = 8'h25;
                dec_alusel = SEL_LOGIC;
                dec_wreg   = 1'b1;
                dec_imm    = imm_lui;
            end
            6'h08, 6'h09: begin
                dec_aluop  = (op == 6'h08) ? 8'h20 : 8'h21;
                dec_alusel = SEL_ARITH;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_imm    = imm_sext;
            end
            6'h23: begin
                dec_aluop  = 8'hE3;
                dec_alusel = SEL_MEM;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_mre    = 1'b1;
                dec_imm    = imm_sext;
            end
            6'h2B: begin
                dec_aluop  = 8'hEB;
                dec_alusel = SEL_MEM;
                dec_re1    = 1'b1;
                dec_re2    = 1'b1;
                dec_mwe    = 1'b1;
                dec_imm    = imm_sext;
            end
            default: dec_inv = 1'b1;
        endcase
    end

    assign reg1_read_o = dec_re1;
    assign reg2_read_o = dec_re2;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    // Register 0 never participates in forwarding or hazards.
    logic use1, use2, ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
    logic [DATA_W-1:0] opnd1, opnd2;

    assign use1     = dec_re1 && (rs != '0);
    assign use2     = dec_re2 && (rt != '0);
    assign ex_hit1  = use1 && ex_wreg_i && (ex_wd_i == rs);
    assign ex_hit2  = use2 && ex_wreg_i && (ex_wd_i == rt);
    assign mem_hit1 = use1 && mem_wreg_i && (mem_wd_i == rs);
    assign mem_hit2 = use2 && mem_wreg_i && (mem_wd_i == rt);

`ifdef DECODE_FORWARD_EN
    // EX is younger than MEM, so its value wins when both match.
    always_comb begin
        opnd1 = '0;
        opnd2 = '0;
        if (use1) opnd1 = ex_hit1 ? ex_wdata_i : mem_hit1 ? mem_wdata_i : reg1_data_i;
        if (use2) opnd2 = ex_hit2 ? ex_wdata_i : mem_hit2 ? mem_wdata_i : reg2_data_i;
    end
    // A load in EX has no data yet, so only that case must wait.
    assign hazard = in_valid && ex_is_load_i && (ex_hit1 || ex_hit2);
`else
    assign opnd1  = use1 ? reg1_data_i : '0;
    assign opnd2  = use2 ? reg2_data_i : '0;
    assign hazard = in_valid && (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2);
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};
`endif

    logic capture;
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush_i;
    assign capture  = in_valid && in_ready;

    logic                   out_valid_q, out_valid_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [7:0]             aluop_q, aluop_d;
    logic [2:0]             alusel_q, alusel_d;
    logic [DATA_W-1:0]      reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
    logic [RADDR_W-1:0]     wd_q, wd_d;
    logic                   wreg_q, wreg_d, mre_q, mre_d, mwe_q, mwe_d, inv_q, inv_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        aluop_d     = aluop_q;
        alusel_d    = alusel_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        imm_d       = imm_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        mre_d       = mre_q;
        mwe_d       = mwe_q;
        inv_d       = inv_q;
        stall_cnt_d = (hazard && !flush_i) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            pc_d        = pc_i;
            aluop_d     = dec_aluop;
            alusel_d    = dec_alusel;
            reg1_d      = opnd1;
            reg2_d      = dec_re2 ? opnd2 : dec_imm;
            imm_d       = dec_imm;
            wd_d        = dec_wd;
            wreg_d      = dec_wreg && (dec_wd != '0);
            mre_d       = dec_mre;
            mwe_d       = dec_mwe;
            inv_d       = dec_inv;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ID/EX register boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            aluop_q     <= '0;
            alusel_q    <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            imm_q       <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            mre_q       <= 1'b0;
            mwe_q       <= 1'b0;
            inv_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            imm_q       <= imm_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            mre_q       <= mre_d;
            mwe_q       <= mwe_d;
            inv_q       <= inv_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign pc_o        = pc_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign reg1_o      = reg1_q;
    assign reg2_o      = reg2_q;
    assign imm_o       = imm_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign mem_re_o    = mre_q;
    assign mem_we_o    = mwe_q;
    assign invalid_o   = inv_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It decodes a MIPS32 integer subset and reads the regfile through combinational read ports. Operands are resolved by EX/MEM forwarding or by stall, and a registered, handshaked decoded bundle goes to execute. Unlike the earlier combinational decoder, it adds valid/ready flow control, flush, load-use interlock, forwarding and a stall counter.

## Interface
- DATA_W, 32: register/operand width.
- PC_W, 32: instruction address width.
- RADDR_W, 5: register address width; register 0 is hardwired zero.
- STALL_CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  handshake from IF/ID.
- pc_i  in  PC_W  instruction address.
- inst_i  in  32  instruction word.
- reg1_read_o, reg2_read_o  out  1  combinational regfile read enables.
- reg1_addr_o, reg2_addr_o  out  RADDR_W  combinational read addresses (rs = inst[25:21], rt = inst[20:16]).
- reg1_data_i, reg2_data_i  in  DATA_W  regfile data, same cycle.
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/RADDR_W/DATA_W/1  EX-stage writeback info.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/RADDR_W/DATA_W  MEM-stage writeback info.
- flush_i  in  1  kill the in-flight and incoming instruction.
- out_valid / out_ready  out / in  1 / 1  handshake to EX.
- pc_o  out  PC_W; aluop_o out 8; alusel_o out 3; reg1_o, reg2_o out DATA_W; imm_o out DATA_W; wd_o out RADDR_W; wreg_o out 1; mem_re_o, mem_we_o out 1; invalid_o out 1.
- stall_cnt_o  out  STALL_CNT_W  saturating count of hazard-stall cycles.

## Operation
- Decode map for `op` = inst[31:26] and `funct` = inst[5:0]. Each entry lists aluop, alusel (LOGIC = 3'b001, ARITH = 3'b100, MEM = 3'b111).
  - R-type (op 0), rd destination, both reads: AND 24h/24h, OR 25h/25h, XOR 26h/26h, NOR 27h/27h, LOGIC; ADD 20h/20h, ADDU 21h/21h, SUB 22h/22h, SLT 2Ah/2Ah, ARITH.
  - funct 00h with inst==0 is NOP: aluop 00h, alusel 000, wreg 0, no reads.
  - ANDI 0Ch, ORI 0Dh, XORI 0Eh: aluop 24h/25h/26h, LOGIC, zero-extended imm, rt destination, reg1 read only.
  - LUI 0Fh: aluop 25h, reg1 = 0, imm = {inst[15:0],16'h0}, rt destination.
  - ADDI 08h, ADDIU 09h: aluop 20h/21h, ARITH, sign-extended imm.
  - LW 23h: aluop E3h, MEM, mem_re 1, rt destination, sign-extended imm.
  - SW 2Bh: aluop EBh, MEM, mem_we 1, wreg 0, both reads.
- Operand select: reg1_o = rs value. reg2_o = rt value when reg2 is read, else imm.
- Any other encoding: invalid_o = 1, wreg 0, mem_re/we 0, aluop 00h.
- Destination 0: wreg_o forced to 0.
- Operand resolution per read port, address ≠ 0, first match wins: EX (ex_wreg_i && ex_wd_i == addr) → ex_wdata_i; MEM match → mem_wdata_i; else regfile. Address 0 → 0.
- Hazard = in_valid && a used read port matches ex_wd_i with ex_wreg_i && ex_is_load_i (load-use).
- in_ready = (!out_valid || out_ready) && !hazard && !flush_i.
- stall_cnt_o increments in every cycle where hazard && !flush_i, and saturates at all-ones.

## Timing
- Decode, forwarding and hazard logic are combinational. Output register latency is 1 cycle: a bundle captured at edge N is presented at cycle N+1.
- Capture when in_valid && in_ready. out_valid is set on capture and cleared when out_valid && out_ready without a capture.
- While out_valid && !out_ready, all outputs hold stable.
- During a hazard with downstream ready, a bubble is inserted: out_valid 0, in_ready 0. The instruction stays on the input until the hazard clears.
- flush_i has priority over everything: next cycle out_valid = 0, and the input is not consumed (in_ready = 0).
- Reset, including mid-stall or mid-handshake: every registered output is 0 (out_valid 0, aluop 00h, alusel 000, invalid 0, stall_cnt 0). in_ready is 1 the first cycle after reset.

## Configuration
- `DECODE_FORWARD_EN` defined: EX/MEM forwarding as above; only load-use stalls.
- Undefined: no forwarding; operands always come from the regfile. Hazard = a used read port matches a nonzero ex_wd_i (with ex_wreg_i) or mem_wd_i (with mem_wreg_i). The bench must cover both builds.

## Test plan
- Reset then ORI 34210005h (r1 = r1|5), regfile r1 = 10h → next cycle out_valid 1, aluop 25h, alusel 001, reg1_o 10h, reg2_o 5h, wd_o 1, wreg_o 1.
- ADDU r3,r1,r2 with ex_wd_i = 1, ex_wdata_i = 7, regfile r1 = 0 (forward build) → reg1_o 7; without forwarding, stall until ex_wreg_i drops, stall_cnt_o increments per cycle.
- LW in EX (ex_is_load_i 1, ex_wd_i 2), then SUB r4,r2,r2 → in_ready 0 for one cycle, one bubble, stall_cnt_o = 1.
- out_ready held 0 for 3 cycles with valid XOR → outputs stable, in_ready 0, no drop/duplicate after release.
- flush_i with out_valid 1 and in_valid 1 → out_valid 0 next cycle, input instruction still presented and accepted later.
- Opcode 3Fh → invalid_o 1, wreg_o 0; ORI r0 → wreg_o 0; reads of r0 return 0 despite ex_wd_i = 0 && ex_wreg_i.
